// File: rtl/alu_pkg.sv
// Shared opcode encodings and control state type for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle after a start pulse.
// o_done is raised for one cycle once the counter has run down from WIDTH to 0.
module alu_div_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_div_zero
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_dz;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_div};
    w_fits   = ~w_trial[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(WIDTH);
      r_busy <= 1'b1;
      r_dz   <= (i_divisor == '0);
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == '0);
  assign o_quotient = r_quo;
  assign o_div_zero = r_dz;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and a multi-cycle divide.
// Optional macro ALU_SAT_EN: ADD saturates to all-ones, SUB to zero.
//
// state   | meaning
// ST_IDLE | single-cycle ops accepted, output regs may be draining
// ST_DIV  | divider iterating, no new operation accepted
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             ovf_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;

  state_t r_state, w_state_nxt;

  logic               w_accept;
  logic               w_start_div;
  logic               w_div_busy;
  logic               w_div_done;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_quo;
  logic               w_load;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_out;
  logic               r_valid;
  logic               r_carry;
  logic               r_zero;
  logic               r_ovf;

  assign in_ready    = (r_state == ST_IDLE) && !w_div_busy && (!r_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_start_div = w_accept && (alu_sel == OP_DIV);
  assign w_load      = (w_accept && (alu_sel != OP_DIV)) || w_div_done;

  alu_div_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start_div),
    .i_dividend (A),
    .i_divisor  (B),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo),
    .o_div_zero (w_div_zero)
  );

  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
`ifdef ALU_SAT_EN
        if (w_sum[WIDTH]) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
`ifdef ALU_SAT_EN
        if (w_diff[WIDTH]) w_res = '0;
`endif
      end
      OP_MUL: begin
        w_res   = w_prod[WIDTH-1:0];
        w_carry = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_SHL: begin
        w_res   = {A[MSB-1:0], 1'b0};
        w_carry = A[MSB];
      end
      OP_SHR: begin
        w_res   = {1'b0, A[MSB:1]};
        w_carry = A[0];
      end
      OP_ROL:  w_res = {A[MSB-1:0], A[MSB]};
      OP_ROR:  w_res = {A[0], A[MSB:1]};
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOR:  w_res = ~(A | B);
      OP_NAND: w_res = ~(A & B);
      OP_XNOR: w_res = ~(A ^ B);
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: w_res = '0;
    endcase
    // Divider completion owns the output path; no accept can coincide with it.
    if (w_div_done) begin
      w_res   = w_div_zero ? '1 : w_quo;
      w_carry = w_div_zero;
      w_ovf   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_out   <= w_res;
      r_valid <= 1'b1;
      r_carry <= w_carry;
      r_zero  <= (w_res == '0);
      r_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_div) w_state_nxt = ST_DIV;
      ST_DIV:  if (w_div_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign out_valid = r_valid;
  assign alu_out   = r_out;
  assign carry_out = r_carry;
  assign zero_out  = r_zero;
  assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus random ops vs a reference model.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   alu_sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         zero_out;
  logic         ovf_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .zero_out  (zero_out),
    .ovf_out   (ovf_out)
  );

  always #5 clk = ~clk;

  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit c, output bit v);
    int t;
    res = 0; c = 0; v = 0;
    case (op)
      0: begin
        t = a + b; res = t & MASK; c = (t > MASK);
        t = to_signed(a) + to_signed(b); v = (t >= HALF) || (t < -HALF);
`ifdef ALU_SAT_EN
        if (c) res = MASK;
`endif
      end
      1: begin
        res = (a - b) & MASK; c = (a < b);
        t = to_signed(a) - to_signed(b); v = (t >= HALF) || (t < -HALF);
`ifdef ALU_SAT_EN
        if (c) res = 0;
`endif
      end
      2: begin t = a * b; res = t & MASK; c = ((t >> W) != 0); end
      3: begin
        if (b == 0) begin res = MASK; c = 1; end
        else res = a / b;
      end
      4:  begin res = (a << 1) & MASK; c = (a >= HALF); end
      5:  begin res = a >> 1; c = a % 2; end
      6:  res = ((a << 1) & MASK) | (a >> (W - 1));
      7:  res = (a >> 1) | ((a % 2) << (W - 1));
      8:  res = a & b;
      9:  res = a | b;
      10: res = a ^ b;
      11: res = ~(a | b) & MASK;
      12: res = ~(a & b) & MASK;
      13: res = ~(a ^ b) & MASK;
      14: res = (a > b) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
  endfunction

  // Issues one op, waits for its result and checks latency and result against the model.
  // Returns at the sample point where out_valid has just risen; in_valid is already low.
  task automatic do_op(input int op, input int a, input int b, input bit expect_ready_now);
    int waits, lat, busy, er;
    bit ec, ev;
    model(op, a, b, er, ec, ev);
    alu_sel = op[3:0]; A = a[W-1:0]; B = b[W-1:0]; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 30) begin
      @(posedge clk); #1; waits++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout op=%0d: in_ready stuck at %b, required 1", op, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (expect_ready_now) begin
      n_checks++;
      if (waits != 0) begin
        n_fail++;
        $display("FAIL ready_stall op=%0d: waited %0d cycles, required 0", op, waits);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== ((op == 3) ? W + 1 : 0)) begin
      n_fail++;
      $display("FAIL latency op=%0d: got %0d extra cycles, required %0d", op, lat, (op == 3) ? W + 1 : 0);
    end
    if (op == 3) begin
      n_checks++;
      if (busy !== W + 1) begin
        n_fail++;
        $display("FAIL div_busy: in_ready low %0d cycles, required %0d", busy, W + 1);
      end
    end
    n_checks++;
    if (alu_out !== er[W-1:0] || carry_out !== ec || ovf_out !== ev || zero_out !== (er == 0)) begin
      n_fail++;
      $display("FAIL result op=%0d a=%0h b=%0h: out=%0h c=%b z=%b v=%b, required out=%0h c=%b z=%b v=%b",
               op, a, b, alu_out, carry_out, zero_out, ovf_out, er[W-1:0], ec, (er == 0), ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || alu_out !== '0 || carry_out !== 1'b0 || zero_out !== 1'b0 || ovf_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b out=%0h c=%b z=%b o=%b, required all 0",
               out_valid, alu_out, carry_out, zero_out, ovf_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_sweep();
    for (int op = 0; op < 16; op++) do_op(op, 'h05, 'h04, 1'b1);
  endtask

  task automatic test_add_edges();
    do_op(0, 'hFF, 'h01, 1'b1);
    do_op(0, 'h7F, 'h01, 1'b1);
    do_op(1, 'h80, 'h01, 1'b1);
    do_op(1, 'h00, 'h01, 1'b1);
    do_op(2, 'h80, 'h02, 1'b1);
  endtask

  task automatic test_div();
    do_op(3, 200, 7, 1'b1);
    n_checks++;
    if (alu_out !== 8'h1C) begin
      n_fail++;
      $display("FAIL div_200_7: out=%0h, required 1c", alu_out);
    end
    do_op(3, 'h33, 0, 1'b1);
    n_checks++;
    if (alu_out !== 8'hFF || carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL div_by_zero: out=%0h c=%b, required ff c=1", alu_out, carry_out);
    end
  endtask

  task automatic test_backpressure();
    int er, er2;
    bit ec, ev, ec2, ev2;
    model(0, 'h12, 'h34, er, ec, ev);
    model(1, 'h50, 'h10, er2, ec2, ev2);
    do_op(0, 'h12, 'h34, 1'b1);
    out_ready = 1'b0;
    alu_sel = 4'd1; A = 8'h50; B = 8'h10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || alu_out !== er[W-1:0] || carry_out !== ec || ovf_out !== ev || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d: v=%b out=%0h c=%b o=%b rdy=%b, required v=1 out=%0h c=%b o=%b rdy=0",
                 i, out_valid, alu_out, carry_out, ovf_out, in_ready, er[W-1:0], ec, ev);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_out !== er2[W-1:0]) begin
      n_fail++;
      $display("FAIL queued_op: v=%b out=%0h, required v=1 out=%0h", out_valid, alu_out, er2[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_div();
    bit saw_valid;
    @(posedge clk); #1;
    alu_sel = 4'd3; A = 8'd200; B = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || alu_out !== '0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_div_reset: v=%b out=%0h c=%b, required 0 0 0", out_valid, alu_out, carry_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL no_partial: saw_valid=%b rdy=%b, required 0 1", saw_valid, in_ready);
    end
    do_op(0, 'h21, 'h13, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int op, a, b;
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, MASK);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      do_op(op, a, b, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_add_edges();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Takes A, B and a 4-bit `alu_sel` opcode under a valid/ready handshake and returns a registered result with carry/zero/overflow flags.
- Divide is iterative and multi-cycle; every other operation completes in 1 cycle.
- Sits between the operand sequencer and the writeback register file.

Parameters:
- WIDTH, 8, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, width of the divide iteration counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- A  input  WIDTH  operand A (unsigned unless stated)
- B  input  WIDTH  operand B
- alu_sel  input  4  opcode
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer accepts result
- alu_out  output  WIDTH  result
- carry_out  output  1  carry / borrow / error flag
- zero_out  output  1  alu_out == 0
- ovf_out  output  1  signed overflow (add/sub only, else 0)

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, alu_out=0, carry_out=0, zero_out=0, ovf_out=0, divide counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Output regs hold stable while out_valid && !out_ready.
- Output regs clear out_valid on out_ready when nothing new is loaded.
- Opcodes (result WIDTH bits, carry_out as listed, else 0):
  - 0 ADD: A+B; carry = bit WIDTH.
  - 1 SUB: A-B; carry = borrow (A<B).
  - 2 MUL: low WIDTH bits of A*B; carry = |upper WIDTH bits.
  - 3 DIV: quotient A/B, multi-cycle.
  - 4 SHL: A<<1; carry = A[MSB].
  - 5 SHR: A>>1; carry = A[0].
  - 6 ROL: rotate A left 1.
  - 7 ROR: rotate A right 1.
  - 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR: bitwise.
  - 14 GT: 1 if A>B else 0.
  - 15 EQ: 1 if A==B else 0.
- ovf_out for ADD/SUB: two's-complement signed overflow of A op B.
- zero_out is computed from the final registered alu_out.
- Non-DIV latency: accepted at edge N → out_valid=1 with result after edge N (one cycle). Back-to-back issue at full throughput while out_ready=1.
- DIV state machine (IDLE → DIV → IDLE):
  - On accepting opcode 3: latch A, B; enter DIV; counter=WIDTH; in_ready=0.
  - Restoring divide, one quotient bit per cycle.
  - When counter reaches 0: load quotient, set out_valid, return to IDLE.
  - out_valid asserts WIDTH+1 cycles after acceptance.
  - A DIV is only accepted when in_ready=1, so the previous output has already drained or is draining.
- Divide by zero (B==0): result all-ones, carry_out=1. Still takes the full WIDTH+1 cycles for fixed latency.
- Reset mid-DIV: aborts immediately to reset values. No partial result is emitted.
- in_valid with in_ready=0: ignored. Upstream holds the operation.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD clamps to all-ones on carry; SUB clamps to 0 on borrow. carry_out and ovf_out still report the unsaturated condition.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.
- No other opcode is affected.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_EQ, 4 bits)
  - state enum (ST_IDLE, ST_DIV)
- Natural sub-module alu_div_iter:
  - restoring divider with start/busy/done
  - WIDTH-parametrised
  - owns the quotient/remainder shift registers and counter
- alu_pipe holds the handshake, single-cycle datapath, and output registers.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Sweep opcodes 0..15 with A=0x05, B=0x04 back-to-back: each result 1 cycle after accept. ADD=0x09; SUB=0x01; MUL=0x14; SHL=0x0A; GT=1; EQ=0; in_ready stays 1 except during DIV.
- ADD 0xFF+0x01 → alu_out=0x00, carry_out=1, zero_out=1; with ALU_SAT_EN → 0xFF, carry_out=1, zero_out=0.
- ADD 0x7F+0x01 → 0x80, ovf_out=1, carry_out=0. SUB 0x80-0x01 → 0x7F, ovf_out=1.
- DIV 200/7 → in_ready=0 for 9 cycles; alu_out=0x1C, out_valid 9 cycles after accept. DIV 0x33/0 → 0xFF, carry_out=1, same latency.
- Backpressure: out_ready=0 for 5 cycles after an ADD result → alu_out/flags stable, in_ready=0. Release → next queued op accepted the same cycle.
- Assert rst_n=0 on cycle 4 of a DIV → out_valid=0 immediately. After release, in_ready=1 and a new ADD completes normally.
